// File: rtl/vector_op_sequencer.sv
// Vector op sequencer: runs one vector instruction lane by lane through a
// shared scalar functional unit, collects the per-lane results (in any order)
// and issues a single vector-register write once every lane has returned.
//
// FU handshake: a lane issue transfers on a rising edge where fu_valid and
// fu_ready are both high. While fu_valid=1 and fu_ready=0, fu_lane/fu_a/fu_b/
// fu_op hold their values. fu_valid never depends on fu_ready. Results come
// back with res_valid and are always accepted (there is no backpressure on
// the result path).
module vector_op_sequencer #(
  parameter  int LANES = 4,
  parameter  int EW    = 16,
  localparam int LW    = $clog2(LANES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [2:0]          op,
  input  logic [LANES*EW-1:0] src_a,
  input  logic [LANES*EW-1:0] src_b,
  input  logic                flush,
  output logic                stall,
  output logic                fu_valid,
  input  logic                fu_ready,
  output logic [2:0]          fu_op,
  output logic [LW-1:0]       fu_lane,
  output logic [EW-1:0]       fu_a,
  output logic [EW-1:0]       fu_b,
  input  logic                res_valid,
  input  logic [LW-1:0]       res_lane,
  input  logic [EW-1:0]       res_data,
  output logic                vec_we,
  output logic [LANES*EW-1:0] vec_result,
  output logic                done,
  output logic [2:0]          dbg_state
);

  localparam int CW = LW + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]          state_q, state_d;
  logic [2:0]          op_q;
  logic [LANES*EW-1:0] a_q;
  logic [LANES*EW-1:0] b_q;
  logic [LANES*EW-1:0] result_q;
  logic [CW-1:0]       issue_cnt_q, issue_cnt_d;
  logic [CW-1:0]       recv_cnt_q, recv_cnt_d;

  logic                in_issue, in_wait, in_drain, in_idle;
  logic                xfer;
  logic                res_count;
  logic                res_write;
  logic                accept;
  logic [LW-1:0]       issue_lane;

  assign in_idle    = (state_q == S_IDLE);
  assign in_issue   = (state_q == S_ISSUE);
  assign in_wait    = (state_q == S_WAIT);
  assign in_drain   = (state_q == S_DRAIN);
  assign issue_lane = issue_cnt_q[LW-1:0];

  // Flush wins over issue: the request is withdrawn in the flush cycle.
  assign fu_valid  = in_issue && !flush;
  assign xfer      = fu_valid && fu_ready;
  assign res_count = res_valid && (in_issue || in_wait || in_drain);
  assign res_write = res_valid && (in_issue || in_wait);
  assign accept    = in_idle && start;

  assign issue_cnt_d = issue_cnt_q + {{LW{1'b0}}, xfer};
  assign recv_cnt_d  = recv_cnt_q + {{LW{1'b0}}, res_count};

  assign fu_op      = op_q;
  assign fu_lane    = issue_lane;
  assign vec_result = result_q;
  assign vec_we     = (state_q == S_DONE);
  assign done       = (state_q == S_DONE);
  assign dbg_state  = state_q;

  // Lane operand select from the latched source vectors.
  always_comb begin
    fu_a = a_q[int'(issue_lane)*EW +: EW];
    fu_b = b_q[int'(issue_lane)*EW +: EW];
  end

  // Front-end stall: held while the op is in flight; in IDLE/DRAIN it only
  // reflects a waiting vector op; released in DONE so that op advances.
  always_comb begin
    stall = 1'b0;
    case (state_q)
      S_ISSUE, S_WAIT:  stall = 1'b1;
      S_IDLE, S_DRAIN:  stall = start;
      default:          stall = 1'b0;
    endcase
  end

  // Next-state logic; counts include any transfer/result of this cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (flush) begin
          state_d = (recv_cnt_d == issue_cnt_q) ? S_IDLE : S_DRAIN;
        end else if (xfer && (issue_lane == LW'(LANES - 1))) begin
          state_d = (recv_cnt_d == CW'(LANES)) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush) begin
          state_d = (recv_cnt_d == issue_cnt_q) ? S_IDLE : S_DRAIN;
        end else if (recv_cnt_d == CW'(LANES)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (recv_cnt_d == issue_cnt_q) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand latch, lane counters and result assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      result_q    <= '0;
    end else if (accept) begin
      op_q        <= op;
      a_q         <= src_a;
      b_q         <= src_b;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      result_q    <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      if (res_write) begin
        result_q[int'(res_lane)*EW +: EW] <= res_data;
      end
    end
  end

endmodule

// File: tb/tb_vector_op_sequencer.sv
// Bench for vector_op_sequencer: a behavioural FU (fixed latency or scheduled
// out-of-order return), directed scenarios with random operands, and a
// scoreboard holding the expected result vector of each accepted op.
module tb_vector_op_sequencer;

  localparam int LANES = 4;
  localparam int EW    = 16;
  localparam int LW    = 2;
  localparam int VW    = LANES * EW;

  localparam logic [2:0] OP_VMUL = 3'b010;
  localparam logic [2:0] OP_VSR  = 3'b011;
  localparam logic [2:0] OP_VSUB = 3'b110;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  logic          clk, rst_n, start, flush, fu_ready, res_valid;
  logic [2:0]    op_i;
  logic [VW-1:0] src_a, src_b;
  logic          stall, fu_valid, vec_we, done;
  logic [2:0]    fu_op, dbg_state;
  logic [LW-1:0] fu_lane, res_lane;
  logic [EW-1:0] fu_a, fu_b, res_data;
  logic [VW-1:0] vec_result;

  vector_op_sequencer #(.LANES(LANES), .EW(EW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op_i),
    .src_a(src_a), .src_b(src_b), .flush(flush), .stall(stall),
    .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_op(fu_op),
    .fu_lane(fu_lane), .fu_a(fu_a), .fu_b(fu_b),
    .res_valid(res_valid), .res_lane(res_lane), .res_data(res_data),
    .vec_we(vec_we), .vec_result(vec_result), .done(done),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic [LW-1:0] lane;
    logic [EW-1:0] data;
  } pend_t;

  pend_t         pend_q[$];
  logic [VW-1:0] exp_q[$];
  logic [LW-1:0] issued_q[$];
  int            sched[int];
  int tests, fails;
  int cyc, t0, n_we, n_stall, we_cyc, flush_at, ready_mode, lat;
  bit auto_ret;
  bit prev_hold;
  logic [LW-1:0] prev_lane;
  logic [EW-1:0] prev_a, prev_b;
  logic [2:0]    ops[3] = '{OP_VMUL, OP_VSR, OP_VSUB};

  // Reference lane function (what the FU computes for each op).
  function automatic logic [EW-1:0] fu_func(input logic [2:0] o,
                                            input logic [EW-1:0] a,
                                            input logic [EW-1:0] b);
    logic [2*EW-1:0] p;
    case (o)
      OP_VMUL: begin p = a * b; return p[EW-1:0]; end
      OP_VSR:  return a >> b[3:0];
      OP_VSUB: return a - b;
      default: return a ^ b;
    endcase
  endfunction

  function automatic logic [VW-1:0] ref_vec(input logic [2:0] o,
                                            input logic [VW-1:0] a,
                                            input logic [VW-1:0] b);
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < LANES; i++) v[i*EW +: EW] = fu_func(o, a[i*EW +: EW], b[i*EW +: EW]);
    return v;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*EW +: EW] = EW'($urandom);
    return v;
  endfunction

  function automatic logic [VW-1:0] lane_seq();
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < issued_q.size() && i < 16; i++) v[i*LW +: LW] = issued_q[i];
    return v;
  endfunction

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive environment inputs after the edge, then sample.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    flush = (cyc == flush_at);
    case (ready_mode)
      0:       fu_ready = 1'b1;
      1:       fu_ready = ((cyc - t0) % 2 == 0);
      default: fu_ready = 1'($urandom_range(0, 1));
    endcase
    res_valid = 1'b0;
    res_lane  = '0;
    res_data  = '0;
    for (int i = 0; i < pend_q.size(); i++) begin
      if ((auto_ret && pend_q[i].due == cyc) ||
          (!auto_ret && sched.exists(cyc) && pend_q[i].lane == LW'(sched[cyc]))) begin
        res_valid = 1'b1;
        res_lane  = pend_q[i].lane;
        res_data  = pend_q[i].data;
        pend_q.delete(i);
        break;
      end
    end
    #1;
    if (prev_hold && fu_valid)
      check("hold", VW'({fu_lane, fu_a, fu_b}), VW'({prev_lane, prev_a, prev_b}));
    prev_hold = fu_valid && !fu_ready;
    prev_lane = fu_lane;
    prev_a    = fu_a;
    prev_b    = fu_b;
    if (fu_valid && fu_ready) begin
      issued_q.push_back(fu_lane);
      pend_q.push_back('{cyc + lat, fu_lane, fu_func(fu_op, fu_a, fu_b)});
    end
    if (stall) n_stall++;
    if (vec_we || done) begin
      n_we++;
      we_cyc = cyc;
      check("we_done", VW'(done), VW'(vec_we));
      if (exp_q.size() == 0) check("unexpected_we", VW'(vec_we), '0);
      else check("vec_result", vec_result, exp_q.pop_front());
    end
  endtask

  // Driver: present a vector op for one accepting edge.
  task automatic launch(input logic [2:0] o, input logic [VW-1:0] a, input logic [VW-1:0] b,
                        input bit expect_we, input bit hold_start);
    op_i  = o;
    src_a = a;
    src_b = b;
    start = 1'b1;
    t0    = cyc;
    n_stall = 0;
    n_we    = 0;
    prev_hold = 1'b0;
    issued_q.delete();
    if (expect_we) exp_q.push_back(ref_vec(o, a, b));
    tick();
    if (!hold_start) start = 1'b0;
  endtask

  task automatic run_to_we(input int budget);
    int k;
    k = 0;
    while (n_we == 0 && k < budget) begin
      tick();
      k++;
    end
    check("we_seen", VW'(n_we), VW'(1));
  endtask

  task automatic check_lanes_in_order();
    check("lane_count", VW'(issued_q.size()), VW'(LANES));
    check("lane_seq", lane_seq(), VW'(8'hE4));
  endtask

  // Hard time limit.
  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VW-1:0] a, b;
    logic [2:0]    o;
    int            t1;
    tests = 0; fails = 0; cyc = 0; t0 = 0; n_we = 0; n_stall = 0; we_cyc = 0;
    flush_at = -1; ready_mode = 0; lat = 2; auto_ret = 1'b1; prev_hold = 1'b0;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; fu_ready = 1'b1; op_i = '0;
    src_a = '0; src_b = '0; res_valid = 1'b0; res_lane = '0; res_data = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_ctrl", VW'({stall, fu_valid, vec_we, done, fu_op, fu_lane, fu_a, fu_b}), '0);
    check("reset_result", vec_result, '0);
    check("reset_state", VW'(dbg_state), VW'(ST_IDLE));
    rst_n = 1'b1;

    // Basic VMUL, latency 2, always ready
    launch(OP_VMUL, {16'd4, 16'd3, 16'd2, 16'd1}, {16'd8, 16'd7, 16'd6, 16'd5}, 1'b1, 1'b0);
    run_to_we(30);
    repeat (2) tick();
    check("basic_stall_cycles", VW'(n_stall), VW'(6));
    check("basic_latency", VW'(we_cyc - t0), VW'(LANES + 2 + 1));
    check("basic_we_pulses", VW'(n_we), VW'(1));
    check("basic_result", vec_result, {16'd32, 16'd21, 16'd12, 16'd5});
    check_lanes_in_order();

    // Backpressure: ready on alternate cycles
    ready_mode = 1;
    launch(ops[$urandom_range(0, 2)], rand_vec(), rand_vec(), 1'b1, 1'b0);
    run_to_we(40);
    repeat (2) tick();
    check("bp_latency", VW'(we_cyc - t0), VW'(LANES + 2 + 1 + 4));
    check("bp_we_pulses", VW'(n_we), VW'(1));
    check_lanes_in_order();
    ready_mode = 0;

    // Out-of-order return 2,0,3,1; lane 2 returns with the lane-3 issue
    auto_ret = 1'b0;
    sched.delete();
    sched[cyc + 4] = 2;
    sched[cyc + 5] = 0;
    sched[cyc + 6] = 3;
    sched[cyc + 7] = 1;
    launch(OP_VSUB, rand_vec(), rand_vec(), 1'b1, 1'b0);
    run_to_we(30);
    repeat (2) tick();
    check("ooo_we_pulses", VW'(n_we), VW'(1));
    check("ooo_latency", VW'(we_cyc - t0), VW'(8));
    check("ooo_pending_empty", VW'(pend_q.size()), '0);
    auto_ret = 1'b1;

    // Flush in ISSUE with two results outstanding, start waiting in DRAIN
    lat = 3;
    flush_at = cyc + 4;
    launch(OP_VSR, rand_vec(), rand_vec(), 1'b0, 1'b0);
    repeat (3) tick();
    check("flush_fu_valid", VW'(fu_valid), '0);
    check("flush_stall", VW'(stall), VW'(1));
    tick();
    check("drain_entered", VW'(dbg_state), VW'(ST_DRAIN));
    a = rand_vec();
    b = rand_vec();
    o = ops[$urandom_range(0, 2)];
    op_i = o; src_a = a; src_b = b; start = 1'b1;
    #1;
    check("drain_start_stall", VW'(stall), VW'(1));
    tick();
    check("drain_hold", VW'(dbg_state), VW'(ST_DRAIN));
    tick();
    check("drain_exit", VW'(dbg_state), VW'(ST_IDLE));
    check("drain_discard", VW'(vec_result[3*EW-1:EW]), '0);
    check("flush_no_we", VW'(n_we), '0);
    flush_at = -1;
    issued_q.delete();
    n_we = 0;
    exp_q.push_back(ref_vec(o, a, b));
    t1 = cyc;
    t0 = cyc;
    tick();
    start = 1'b0;
    check("post_drain_accept", VW'(dbg_state), VW'(ST_ISSUE));
    run_to_we(30);
    repeat (2) tick();
    check("post_drain_latency", VW'(we_cyc - t1), VW'(LANES + 3 + 1));
    check_lanes_in_order();

    // Reset mid-ISSUE after two lanes issued
    lat = 2;
    launch(ops[$urandom_range(0, 2)], rand_vec(), rand_vec(), 1'b0, 1'b0);
    repeat (2) tick();
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_ctrl", VW'({stall, fu_valid, vec_we, done, fu_op, fu_lane, fu_a, fu_b}), '0);
    check("rst_mid_result", vec_result, '0);
    check("rst_mid_state", VW'(dbg_state), VW'(ST_IDLE));
    pend_q.delete();
    res_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_no_expect", VW'(exp_q.size()), '0);
    launch(ops[$urandom_range(0, 2)], rand_vec(), rand_vec(), 1'b1, 1'b0);
    run_to_we(30);
    repeat (2) tick();
    check("rst_next_we", VW'(n_we), VW'(1));
    check_lanes_in_order();

    // start held high through DONE
    launch(OP_VMUL, rand_vec(), rand_vec(), 1'b1, 1'b1);
    run_to_we(30);
    check("done_stall", VW'(stall), '0);
    issued_q.delete();
    tick();
    check("after_done_state", VW'(dbg_state), VW'(ST_IDLE));
    check("after_done_fu_valid", VW'(fu_valid), '0);
    start = 1'b0;
    repeat (3) tick();
    check("no_second_op", VW'(issued_q.size()), '0);
    check("held_start_we", VW'(n_we), VW'(1));

    // Random ops: random op, operands, readiness and FU latency
    ready_mode = 2;
    for (int n = 0; n < 6; n++) begin
      lat = $urandom_range(1, 4);
      launch(ops[$urandom_range(0, 2)], rand_vec(), rand_vec(), 1'b1, 1'b0);
      run_to_we(80);
      repeat (2) tick();
      check("rand_we_pulses", VW'(n_we), VW'(1));
      check_lanes_in_order();
    end
    ready_mode = 0;

    check("scoreboard_empty", VW'(exp_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vector_op_sequencer.md
Name: vector_op_sequencer

Overview:
- Sequences one vector instruction (VMUL, VSR, VSUB) lane by lane through a single shared scalar functional unit (FU).
- Sits between decode/control and the vector register file.
- Stalls the pipeline while busy, collects per-lane results, and issues one vector-register write when all lanes have returned.

Parameters:
- LANES, 4, number of vector elements; power of two, at least 2.
- EW, 16, element width in bits.
- LW, $clog2(LANES), lane index width (derived; not overridden).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous reset, active low.
- start  in  1  decoded vector op is present in decode (WriteRegisterVec from control).
- op  in  3  ALUOp of the vector instruction; passed to the FU unchanged.
- src_a  in  LANES*EW  packed vector operand A; lane i is bits [i*EW +: EW].
- src_b  in  LANES*EW  packed vector operand B, same packing as src_a.
- flush  in  1  synchronous pipeline flush; aborts the current op.
- stall  out  1  holds the front end of the pipeline.
- fu_valid  out  1  lane issue request to the FU.
- fu_ready  in  1  FU accepts the issue this cycle.
- fu_op  out  3  latched op.
- fu_lane  out  LW  index of the lane being issued.
- fu_a  out  EW  lane operand A.
- fu_b  out  EW  lane operand B.
- res_valid  in  1  FU result return.
- res_lane  in  LW  lane tag of the returned result.
- res_data  in  EW  result value.
- vec_we  out  1  vector register file write enable, one-cycle pulse.
- vec_result  out  LANES*EW  assembled result vector.
- done  out  1  one-cycle pulse coincident with vec_we.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Go to IDLE; clear all counters and latches.
  - fu_valid=0, vec_we=0, done=0, stall=0, vec_result=0, fu_op/fu_lane/fu_a/fu_b=0.
  - Reset asserted mid-operation discards the op completely.
- States: IDLE, ISSUE, WAIT, DONE, DRAIN.
  - issue_cnt and recv_cnt are LW+1 bits wide.
- stall (combinational):
  - 1 in ISSUE and WAIT.
  - Equals start in IDLE and DRAIN.
  - 0 in DONE.
- IDLE:
  - If start=1, latch op, src_a and src_b; clear issue_cnt, recv_cnt and vec_result; go to ISSUE.
  - res_valid is ignored.
- ISSUE:
  - fu_valid=1, fu_lane=issue_cnt[LW-1:0], fu_a/fu_b = latched lane issue_cnt.
  - A transfer occurs when fu_valid and fu_ready are both 1; issue_cnt increments on each transfer.
  - fu_a/fu_b/fu_lane stay stable while fu_ready=0.
  - On transfer of lane LANES-1, go to WAIT.
  - If the last lane's result returns in the same cycle that completes the count, go directly to DONE.
- Result collection (ISSUE, WAIT, DRAIN):
  - res_valid=1 increments recv_cnt.
  - Outside DRAIN, res_data is also written into vec_result lane res_lane.
  - Results may return out of order and may arrive in the same cycle as an issue.
- WAIT:
  - fu_valid=0.
  - When recv_cnt reaches LANES (counting a res_valid in this cycle), go to DONE.
- DONE:
  - Lasts exactly one cycle: vec_we=1, done=1, then IDLE.
  - start is ignored here; the stalled instruction advances this cycle.
- flush (ISSUE, WAIT): highest priority.
  - fu_valid drops the same cycle; no vec_we is issued.
  - If issue_cnt equals recv_cnt after counting this cycle, go to IDLE; otherwise go to DRAIN.
  - flush in IDLE, DONE or DRAIN has no effect.
- DRAIN:
  - fu_valid=0; results are counted and discarded.
  - Go to IDLE when recv_cnt equals issue_cnt.
  - A new start is not accepted until IDLE.
- vec_result holds its value from DONE until the next accepted start.
- Latency: with fu_ready=1 and FU latency L, start to vec_we is LANES+L+1 cycles.
- res_valid for an already-written lane overwrites it; this is not detected.

Test Plan:
- Basic op: LANES=4, EW=16, VMUL op=3'b010, src_a={4,3,2,1}, src_b={8,7,6,5}, fu_ready=1, FU latency 2 returning products.
  - Required: stall high for exactly 6 cycles after the start edge, fu_lane sequence 0,1,2,3, vec_we/done single pulse, vec_result={32,21,12,5}.
- Backpressure: fu_ready low on alternate cycles.
  - Required: fu_lane, fu_a and fu_b held while fu_ready=0, each lane issued once, correct vec_result, vec_we delayed by 4 cycles.
- Out-of-order return: results for lanes 2,0,3,1, including one in the same cycle as the lane-3 issue.
  - Required: vec_result correct, exactly one vec_we.
- Flush with 2 results outstanding:
  - Required: fu_valid low in the flush cycle, DRAIN entered, both late results discarded, no vec_we.
  - A start presented during DRAIN sees stall=1 and is accepted only after return to IDLE.
- Reset mid-ISSUE after 2 lanes issued:
  - Required: all outputs 0 immediately, and a subsequent op completes correctly with no stale lanes.
- start held high through DONE:
  - Required: no second op is launched, stall=0 in DONE, and IDLE is reached with no fu_valid.
